// File: rtl/board_io_conditioner_pkg.sv
// Shared types and constants for the board I/O front end: bell FSM states,
// a constant-friendly clog2, and timing defaults for the 50 MHz board clock.
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } bell_state_e;

  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = DEF_CLK_HZ / 1000;  // 1 ms
  localparam int DEF_BEEP_CYCLES     = DEF_CLK_HZ / 10;    // 100 ms
  localparam int DEF_GAP_CYCLES      = DEF_CLK_HZ / 10;    // 100 ms

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/board_io_conditioner_if.sv
// SoC-side GPIO/interrupt bundle of the board I/O conditioner.
// master = SoC GPIO block, slave = conditioner.
interface board_io_conditioner_if #(
  parameter int NUM_IN   = 6,
  parameter int NUM_LED  = 8,
  parameter int PWM_BITS = 8
);
  logic [NUM_IN-1:0]   io_inStable;
  logic [NUM_IN-1:0]   io_inRise;
  logic [NUM_IN-1:0]   io_inFall;
  logic [NUM_LED-1:0]  io_ledValue;
  logic [PWM_BITS-1:0] io_ledBrightness;
  logic                io_bellTrigger;
  logic [3:0]          io_bellCount;
  logic                io_bellBusy;

  modport master (
    input  io_inStable, io_inRise, io_inFall, io_bellBusy,
    output io_ledValue, io_ledBrightness, io_bellTrigger, io_bellCount
  );

  modport slave (
    output io_inStable, io_inRise, io_inFall, io_bellBusy,
    input  io_ledValue, io_ledBrightness, io_bellTrigger, io_bellCount
  );
endinterface

// File: rtl/board_io_conditioner_debounce.sv
// One input channel: polarity fix, 2-flop synchroniser, persistence-count
// debounce and single-cycle rise/fall pulses aligned with the stable update.
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int               CNT_W    = clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any return to the stable level restarts the persistence count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q + CNT_W'(1);
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = s2_q;
      cnt_d    = '0;
      rise_d   = s2_q;
      fall_d   = ~s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i ^ INVERT;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
endmodule

// File: rtl/board_io_conditioner.sv
// Board pin front end: debounced inputs with edge pulses, global PWM dimming
// of the LED bank, and a multi-beep bell sequencer.
module board_io_conditioner
  import board_io_pkg::*;
#(
  parameter int              NUM_IN             = 6,
  parameter logic [NUM_IN-1:0] IN_ACTIVE_LOW_MASK = 6'b110000,
  parameter int              DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int              NUM_LED            = 8,
  parameter int              PWM_BITS           = 8,
  parameter int              BEEP_CYCLES        = DEF_BEEP_CYCLES,
  parameter int              GAP_CYCLES         = DEF_GAP_CYCLES,
  parameter bit              BELL_ACTIVE_LOW    = 1'b1
) (
  input  logic                io_axiClk,
  input  logic                io_asyncReset,
  input  logic [NUM_IN-1:0]   io_rawIn,
  output logic [NUM_LED-1:0]  io_ledOut,
  output logic                io_bellOut,
  board_io_conditioner_if.slave gpio
);

  // ---------------- input channels ----------------
  logic [NUM_IN-1:0] in_stable, in_rise, in_fall;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .INVERT         (IN_ACTIVE_LOW_MASK[i])
    ) u_db (
      .clk     (io_axiClk),
      .rst     (io_asyncReset),
      .raw_i   (io_rawIn[i]),
      .stable_o(in_stable[i]),
      .rise_o  (in_rise[i]),
      .fall_o  (in_fall[i])
    );
  end

  assign gpio.io_inStable = in_stable;
  assign gpio.io_inRise   = in_rise;
  assign gpio.io_inFall   = in_fall;

  // ---------------- LED PWM ----------------
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic [PWM_BITS-1:0] pwm_cnt_q, lat_q;
  logic [NUM_LED-1:0]  led_q;
  logic                pwm_on;

  // Full-scale is forced on so brightness all-ones really means 100 %.
  assign pwm_on = (lat_q == PWM_MAX) || (pwm_cnt_q < lat_q);

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      pwm_cnt_q <= '0;
      lat_q     <= '0;
      led_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == PWM_MAX) lat_q <= gpio.io_ledBrightness;
      led_q <= gpio.io_ledValue & {NUM_LED{pwm_on}};
    end
  end

  assign io_ledOut = led_q;

  // ---------------- bell sequencer ----------------
  localparam int PH_MAX = (BEEP_CYCLES > GAP_CYCLES) ? BEEP_CYCLES : GAP_CYCLES;
  localparam int PH_W   = clog2(PH_MAX) + 1;
  localparam logic [PH_W-1:0] BEEP_LAST = PH_W'(BEEP_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYCLES - 1);

  bell_state_e     state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [3:0]      rem_q, rem_d;
  logic            bell_q, bell_d;

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q <= IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      bell_q  <= BELL_ACTIVE_LOW;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      bell_q  <= bell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PH_W'(1);
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (gpio.io_bellTrigger && (gpio.io_bellCount != 4'd0)) begin
          rem_d   = gpio.io_bellCount;
          state_d = ON;
        end
      end
      ON: begin
        if (phase_q == BEEP_LAST) begin
          phase_d = '0;
          rem_d   = rem_q - 4'd1;
          state_d = (rem_q == 4'd1) ? IDLE : OFF;
        end
      end
      OFF: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = ON;
        end
      end
      default: begin
        phase_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Pin is driven from the next state so the first beep cycle follows the trigger edge.
  always_comb begin
    bell_d = (state_d == ON) ? ~BELL_ACTIVE_LOW : BELL_ACTIVE_LOW;
  end

  assign gpio.io_bellBusy = (state_q != IDLE);
  assign io_bellOut       = bell_q;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Directed bench for board_io_conditioner: debounce, glitch rejection, PWM
// duty/latching, bell sequencing and asynchronous reset.
module tb_board_io_conditioner;
  localparam int NUM_IN = 2;
  localparam int NUM_LED = 8;
  localparam int PWM_BITS = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_IN-1:0]  raw;
  logic [NUM_LED-1:0] led_out;
  logic               bell_out;
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int                 ecnt;

  board_io_conditioner_if #(.NUM_IN(NUM_IN), .NUM_LED(NUM_LED), .PWM_BITS(PWM_BITS)) gpio ();

  board_io_conditioner #(
    .NUM_IN(NUM_IN), .IN_ACTIVE_LOW_MASK(2'b10), .DEBOUNCE_CYCLES(4),
    .NUM_LED(NUM_LED), .PWM_BITS(PWM_BITS), .BEEP_CYCLES(3), .GAP_CYCLES(2),
    .BELL_ACTIVE_LOW(1'b1)
  ) dut (
    .io_axiClk    (clk),
    .io_asyncReset(rst),
    .io_rawIn     (raw),
    .io_ledOut    (led_out),
    .io_bellOut   (bell_out),
    .gpio         (gpio)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the PWM counter phase equals ecnt mod 16.
  always @(posedge clk or posedge rst)
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic led_window(output int hi, output logic [NUM_LED-1:0] other);
    hi = 0;
    other = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (led_out[0]) hi++;
      other |= {led_out[NUM_LED-1:1], 1'b0};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NUM_LED-1:0] other;
    logic [5:0]         acc;
    logic [0:9]         eo, eb;
    int                 hi;
    logic               busy_acc, out_acc;

    rst = 1'b1;
    raw = '0;
    gpio.io_ledValue = '0;
    gpio.io_ledBrightness = '0;
    gpio.io_bellTrigger = 1'b0;
    gpio.io_bellCount = 4'd0;
    #1;
    chk("rst_stable", gpio.io_inStable, 0);
    chk("rst_rise", gpio.io_inRise, 0);
    chk("rst_fall", gpio.io_inFall, 0);
    chk("rst_led", led_out, 0);
    chk("rst_busy", gpio.io_bellBusy, 0);
    chk("rst_bell", bell_out, 1);

    // 1. clean change, visible on edge 6 after first sampling edge
    ticks(2);
    rst = 1'b0;
    raw = 2'b01;
    ticks(5);
    chk("db_e5_stable", gpio.io_inStable, 2'b00);
    tick();
    chk("db_e6_stable", gpio.io_inStable, 2'b11);
    chk("db_e6_rise", gpio.io_inRise, 2'b11);
    chk("db_e6_fall", gpio.io_inFall, 2'b00);
    tick();
    chk("db_e7_rise", gpio.io_inRise, 2'b00);
    chk("db_e7_stable", gpio.io_inStable, 2'b11);

    raw = 2'b00;
    ticks(5);
    chk("fall_e5_stable", gpio.io_inStable, 2'b11);
    tick();
    chk("fall_e6_stable", gpio.io_inStable, 2'b10);
    chk("fall_e6_pulse", gpio.io_inFall, 2'b01);

    // 2. three-cycle glitch is rejected
    raw = 2'b01;
    acc = '0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i == 2) raw = 2'b00;
      acc |= {gpio.io_inRise, gpio.io_inFall, gpio.io_inStable ^ 2'b10};
    end
    chk("glitch", acc, 0);

    // 3. PWM duty and wrap-aligned brightness latch
    gpio.io_ledValue = 8'h01;
    gpio.io_ledBrightness = 4'd4;
    ticks(32);
    led_window(hi, other);
    chk("pwm4_hi", hi, 4);
    chk("pwm_other_leds", other, 0);

    for (int i = 0; i < 16 && (ecnt % 16) != 4; i++) tick();
    gpio.io_ledBrightness = 4'd12;
    out_acc = 1'b0;
    repeat (12) begin
      tick();
      out_acc |= led_out[0];
    end
    chk("pwm_no_midchange", out_acc, 0);
    led_window(hi, other);
    chk("pwm12_hi", hi, 12);

    gpio.io_ledBrightness = 4'd15;
    ticks(32);
    led_window(hi, other);
    chk("pwm15_hi", hi, 16);
    gpio.io_ledBrightness = 4'd0;
    ticks(32);
    led_window(hi, other);
    chk("pwm0_hi", hi, 0);

    // 4. two beeps, retrigger while busy ignored
    eo = 10'b0001100011;
    eb = 10'b1111111100;
    gpio.io_bellCount = 4'd2;
    gpio.io_bellTrigger = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("bell_out_%0d", k), bell_out, eo[k]);
      chk($sformatf("bell_busy_%0d", k), gpio.io_bellBusy, eb[k]);
      if (k == 0) gpio.io_bellTrigger = 1'b0;
      if (k == 3) gpio.io_bellTrigger = 1'b1;
      if (k == 4) gpio.io_bellTrigger = 1'b0;
    end

    // 5. count of zero is ignored
    gpio.io_bellCount = 4'd0;
    gpio.io_bellTrigger = 1'b1;
    busy_acc = 1'b0;
    out_acc = 1'b1;
    repeat (4) begin
      tick();
      busy_acc |= gpio.io_bellBusy;
      out_acc &= bell_out;
    end
    gpio.io_bellTrigger = 1'b0;
    chk("cnt0_busy", busy_acc, 0);
    chk("cnt0_bell", out_acc, 1);

    // 6. async reset during a beep and a debounce count
    gpio.io_ledValue = 8'h01;
    gpio.io_ledBrightness = 4'd15;
    ticks(32);
    chk("pre_rst_led", led_out, 8'h01);
    raw = 2'b01;
    ticks(2);
    gpio.io_bellCount = 4'd3;
    gpio.io_bellTrigger = 1'b1;
    tick();
    gpio.io_bellTrigger = 1'b0;
    tick();
    chk("pre_rst_bell", bell_out, 0);
    chk("pre_rst_stable", gpio.io_inStable, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("async_bell", bell_out, 1);
    chk("async_busy", gpio.io_bellBusy, 0);
    chk("async_led", led_out, 0);
    chk("async_stable", gpio.io_inStable, 0);
    tick();
    rst = 1'b0;
    ticks(5);
    chk("post_rst_e5_stable", gpio.io_inStable, 2'b00);
    tick();
    chk("post_rst_e6_stable", gpio.io_inStable, 2'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
